vga_timing_ctrl: RTL
====================

Name: vga_timing_ctrl

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock.
- Issues per-pixel coordinate requests one cycle ahead to the upstream pixel generator, takes its RGB565 data back, and drives hsync/vsync/rgb to the VGA connector.
- Sits directly upstream of the colour-pattern display logic: the display stage consumes pix_x/pix_y and returns pix_data.

Parameters:
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 40, horizontal back porch
- H_LEFT, 8, left border
- H_VALID, 640, active pixels per line
- H_RIGHT, 8, right border
- H_FRONT, 8, front porch; line total is 800
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 25, vertical back porch
- V_TOP, 8, top border
- V_VALID, 480, active lines
- V_BOTTOM, 8, bottom border
- V_FRONT, 2, front porch; frame total is 525

Ports:
- vga_clk  input  1  pixel clock, 25 MHz
- sys_rst_n  input  1  asynchronous active-low reset
- pix_data  input  16  RGB565 pixel for the coordinate requested in the previous cycle
- pix_x  output  10  requested column 0..639; 10'h3FF outside request window
- pix_y  output  10  requested row 0..479; 10'h3FF outside request window
- hsync  output  1  line sync, active high
- vsync  output  1  field sync, active high
- rgb  output  16  RGB565 to DAC; 16'h0000 outside active window
- frame_cnt  output  16  frames completed (optional feature)

Behaviour:
- Reset: one clock domain, vga_clk. sys_rst_n is asynchronous, active-low.
- Counters:
  - cnt_h counts 0..H_TOTAL-1 (799) and wraps to 0.
  - cnt_v increments when cnt_h==799 and wraps 524->0 on the same edge that cnt_h wraps.
  - Both counters are 10-bit registers and clear to 0 on reset.
- hsync = (cnt_h <= H_SYNC-1), so it is high for cnt_h 0..95.
- vsync = (cnt_v <= V_SYNC-1), so it is high for cnt_v 0..1. Both are decoded from the registered counters.
- Active window (rgb_valid, internal):
  - H_START = H_SYNC+H_BACK+H_LEFT = 144; active cnt_h 144..783.
  - V_START = 35; active cnt_v 35..514.
- Request window (pix_data_req, internal):
  - Same vertical range as the active window.
  - Horizontal range shifted one clock early: cnt_h 143..782.
- Coordinates:
  - pix_x = cnt_h-(H_START-1) when req is high, else 10'h3FF.
  - pix_y = cnt_v-V_START when req is high, else 10'h3FF.
  - Subtraction is unsigned 10-bit and never underflows inside the window.
- Data path:
  - rgb = pix_data when rgb_valid is high, else 16'h0000.
  - Upstream must register pix_data from pix_x/pix_y, a one-cycle latency, so pixel (x,y) appears on rgb at cnt_h = 144+x.
- Reset values during reset:
  - cnt_h=cnt_v=0, hence hsync=1, vsync=1.
  - rgb=0, pix_x=pix_y=10'h3FF, frame_cnt=0.
- Reset mid-frame: counters return to 0 asynchronously. On the first edge after release, cnt_h=1 and the raster restarts at the start of the sync region. No partial-frame state is retained.
- Boundaries:
  - Last active pixel (cnt_h=783, cnt_v=514) outputs pix_data.
  - cnt_h=784 forces rgb to 0.
  - Line 514 wraps into the bottom border with no requests issued.
  - cnt_h=142 and cnt_h=783 present pix_x=3FF.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- When defined:
  - frame_cnt is a 16-bit register, cleared on reset.
  - It increments on the edge where cnt_h==799 and cnt_v==524.
  - It wraps FFFF->0000.
- When not defined: frame_cnt is tied to 16'h0000 and no counter logic is synthesised.

Test Plan:
- Reset held 10 clocks, then released -> during reset hsync=1, vsync=1, rgb=0, pix_x=pix_y=3FF; one clock after release cnt_h=1.
- Run one full line -> hsync high for exactly 96 clocks; period 800 clocks; vsync high for exactly 1600 clocks (2 lines); frame period 420000 clocks.
- Upstream model returns pix_data={pix_y[4:0],pix_x[5:0],pix_y[4:0]} registered -> first active pixel at cnt_h=144,cnt_v=35 shows rgb for (0,0); pixel (639,479) at cnt_h=783,cnt_v=514; exactly 307200 non-blanked samples per frame.
- pix_data tied to 16'hFFFF -> rgb=FFFF only inside the active window; rgb=0000 at cnt_h=143 and 784, and on lines 34 and 515.
- Assert reset at cnt_h=400,cnt_v=200 for 3 clocks -> counters and outputs return to reset values immediately; the next frame timing is identical to the post-power-on frame.
- With VGA_FRAME_CNT_EN: run 3 frames -> frame_cnt=3, incrementing only at the 799/524 wrap. Without the macro: frame_cnt stays 0.

Source files
------------

// File: rtl/vga_timing_ctrl_if.sv
// Pixel request/response bus between the VGA timing controller (master)
// and the upstream pixel generator (slave).
interface vga_timing_ctrl_if;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [15:0] pix_data;

    modport master (output pix_x, output pix_y, input  pix_data);
    modport slave  (input  pix_x, input  pix_y, output pix_data);
endinterface

// File: rtl/vga_timing_ctrl.sv
// 640x480@60 VGA raster timing with one-cycle-ahead pixel requests.
// Optional frame counter enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_ctrl #(
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 40,
    parameter int unsigned H_LEFT   = 8,
    parameter int unsigned H_VALID  = 640,
    parameter int unsigned H_RIGHT  = 8,
    parameter int unsigned H_FRONT  = 8,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 25,
    parameter int unsigned V_TOP    = 8,
    parameter int unsigned V_VALID  = 480,
    parameter int unsigned V_BOTTOM = 8,
    parameter int unsigned V_FRONT  = 2
) (
    input  logic              vga_clk,
    input  logic              sys_rst_n,
    vga_timing_ctrl_if.master pix_if,
    output logic              hsync,
    output logic              vsync,
    output logic [15:0]       rgb,
    output logic [15:0]       frame_cnt
);

    localparam int unsigned H_TOT = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
    localparam int unsigned V_TOT = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;
    localparam int unsigned H_ST  = H_SYNC + H_BACK + H_LEFT;
    localparam int unsigned V_ST  = V_SYNC + V_BACK + V_TOP;

    localparam logic [9:0] H_LAST      = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOT - 1);
    localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
    localparam logic [9:0] H_START     = 10'(H_ST);
    localparam logic [9:0] H_STOP      = 10'(H_ST + H_VALID);
    localparam logic [9:0] H_REQ_START = 10'(H_ST - 1);
    localparam logic [9:0] H_REQ_STOP  = 10'(H_ST + H_VALID - 1);
    localparam logic [9:0] V_START     = 10'(V_ST);
    localparam logic [9:0] V_STOP      = 10'(V_ST + V_VALID);

    logic [9:0] cnt_h_q, cnt_h_d;
    logic [9:0] cnt_v_q, cnt_v_d;
    logic       line_end;
    logic       v_win;
    logic       rgb_valid;
    logic       pix_data_req;

    always_comb begin
        line_end = (cnt_h_q == H_LAST);
        cnt_h_d  = line_end ? 10'd0 : cnt_h_q + 10'd1;
        cnt_v_d  = cnt_v_q;
        if (line_end) begin
            cnt_v_d = (cnt_v_q == V_LAST) ? 10'd0 : cnt_v_q + 10'd1;
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h_q <= 10'd0;
            cnt_v_q <= 10'd0;
        end else begin
            cnt_h_q <= cnt_h_d;
            cnt_v_q <= cnt_v_d;
        end
    end

    // Request window leads the active window by one clock so the
    // upstream register lines its data up with rgb_valid.
    always_comb begin
        v_win        = (cnt_v_q >= V_START) && (cnt_v_q < V_STOP);
        rgb_valid    = v_win && (cnt_h_q >= H_START) && (cnt_h_q < H_STOP);
        pix_data_req = v_win && (cnt_h_q >= H_REQ_START) && (cnt_h_q < H_REQ_STOP);
    end

    assign hsync        = (cnt_h_q < H_SYNC_END);
    assign vsync        = (cnt_v_q < V_SYNC_END);
    assign pix_if.pix_x = pix_data_req ? cnt_h_q - H_REQ_START : 10'h3FF;
    assign pix_if.pix_y = pix_data_req ? cnt_v_q - V_START     : 10'h3FF;
    assign rgb          = rgb_valid ? pix_if.pix_data : 16'h0000;

`ifdef VGA_FRAME_CNT_EN
    logic        frame_end;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_end   = line_end && (cnt_v_q == V_LAST);
        frame_cnt_d = frame_end ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) frame_cnt_q <= 16'h0000;
        else            frame_cnt_q <= frame_cnt_d;
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 16'h0000;
`endif

endmodule
